logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit: eight selectable WIDTH-bit ops (NAND, INV, AND, OR, XOR,
//  NOR, XNOR, PASS_B), with an optional internal accumulator as operand A. Result lands in a 2-entry
//  output FIFO behind valid/ready handshakes. Logic-op stage of the ALU datapath.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      input transaction offered
//  in_ready    out  1      unit can accept; registered, no comb path from out_ready
//  in_a        in   WIDTH  operand A (ignored when in_acc=1)
//  in_b        in   WIDTH  operand B
//  in_op       in   3      op select (see BEHAVIOUR)
//  in_acc      in   1      1: operand A = accumulator register
//  out_valid   out  1      FIFO head valid
//  out_ready   in   1      consumer takes head
//  out_result  out  WIDTH  FIFO head result; 0 when empty
//  out_zero    out  1      head result == 0; 0 when empty
//  acc_value   out  WIDTH  current accumulator contents
// BEHAVIOUR
//  - Ops: 000 ~(A&B); 001 ~A; 010 A&B; 011 A|B; 100 A^B; 101 ~(A|B); 110 ~(A^B); 111 B.
//  - Accept = in_valid & in_ready (sampled at rising clk). Pop = out_valid & out_ready.
//  - On accept: result computed from this cycle's inputs (A = acc_value if in_acc), written to FIFO tail;
//    acc_value <= result. Accumulator updates on every accept, whether or not in_acc is set.
//  - Latency: accept at edge N -> out_valid/out_result visible after edge N (1 cycle) if FIFO was empty.
//  - FIFO: 2 entries, in-order; count in {0,1,2}. in_ready = (count != 2) as registered state, i.e.
//    in_ready reflects count after the previous edge.
//  - Simultaneous accept + pop: count unchanged; head advances, new entry appended behind.
//  - Full (count=2): in_ready=0; in_valid ignored. A pop at count=2 raises in_ready next cycle.
//  - Empty (count=0): out_valid=0, out_result=0, out_zero=0; out_ready ignored.
//  - out_zero computed at write time and stored with each entry (WIDTH+1 bits per entry).
//  - Inputs are don't-care when not accepted; no X propagates into stored state.
//  - rst (sync, priority over all): count=0, FIFO contents=0, acc_value=0, out_valid=0,
//    out_result=0, out_zero=0, in_ready=0 while rst=1, in_ready=1 on the first cycle after rst falls.
//  - Reset mid-operation: buffered results discarded, accumulator cleared; no pop reported.
//  - Producer must hold in_* stable while in_valid=1 & in_ready=0; consumer sees stable head until pop.
// TESTING (WIDTH=16)
//  1 All ops: A=16'hF0F0, B=16'hFF00, out_ready=1 -> results 0FFF,0F0F,F000,FFF0,0FF0,000F,F00F,FF00,
//    one per cycle, each 1 cycle after accept; out_zero=0 throughout.
//  2 Accumulate: op=011 A=0001 in_acc=0, then op=100 B=0001 in_acc=1, then op=001 in_acc=1 ->
//    results 0001, 0000 (out_zero=1), FFFF; acc_value follows 0001,0000,FFFF.
//  3 Backpressure: out_ready=0, 3 back-to-back offers -> 2 accepted, in_ready=0 after 2nd edge,
//    3rd held; raise out_ready -> in-order drain of all 3, no loss or duplication.
//  4 Full + simultaneous: count=2, out_ready=1 for 1 cycle -> in_ready=1 next cycle; then accept+pop
//    same edge at count=1 -> count stays 1, order preserved.
//  5 Reset mid-stream: count=2, acc=ABCD, assert rst 1 cycle -> out_valid=0, out_result=0,
//    acc_value=0, in_ready=0 during rst, 1 the cycle after.
//  6 Random: 10k random ops/handshakes vs. reference model -> zero mismatches.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with optional accumulator operand and a 2-entry result FIFO.
// Latency 1 cycle into an empty FIFO; in_ready drops when the FIFO is full, independent of out_ready.
module logic_unit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc_value
);

  typedef struct packed {
    logic             zero;
    logic [WIDTH-1:0] res;
  } entry_t;

  entry_t           mem_q [2];
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] op_a, res_d;
  logic             accept, pop;

  // in_ready comes from the count register; rst masks it so nothing is taken during reset.
  assign in_ready  = ~rst & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = out_valid ? mem_q[rd_ptr_q].res  : '0;
  assign out_zero   = out_valid ? mem_q[rd_ptr_q].zero : 1'b0;
  assign acc_value  = acc_q;

  always_comb begin
    op_a  = in_acc ? acc_q : in_a;
    res_d = '0;
    case (in_op)
      3'b000:  res_d = ~(op_a & in_b);
      3'b001:  res_d = ~op_a;
      3'b010:  res_d = op_a & in_b;
      3'b011:  res_d = op_a | in_b;
      3'b100:  res_d = op_a ^ in_b;
      3'b101:  res_d = ~(op_a | in_b);
      3'b110:  res_d = ~(op_a ^ in_b);
      default: res_d = in_b;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= {(res_d == '0), res_d};
        wr_ptr_q        <= ~wr_ptr_q;
        acc_q           <= res_d;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule
